any1_dispatcher: RTL and testbench
==================================

ANY1_DISPATCHER -- requirements
Module: any1_dispatcher

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, meaning dispatch queue depth in entries (power of two).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 4, meaning max dispatched-but-uncompleted ops (at most 7).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sel_i  input  7  scheduler selection; bit6=0 means valid, bits5:0 = ROB slot; 7'h7F means none.
REQ-006 SHALL have port sel_branch_i  input  1  selected entry is a branch.
REQ-007 SHALL have port sel_mem_i  input  1  selected entry is a memory op.
REQ-008 SHALL have port flush_i  input  1  discard all queued, undispatched entries.
REQ-009 SHALL have port ex_valid_o  output  1  dispatch request to execute stage.
REQ-010 SHALL have port ex_ready_i  input  1  execute stage accepts this cycle.
REQ-011 SHALL have ports ex_rid_o  output  6, ex_branch_o  output  1, ex_mem_o  output  1, giving the queue-head entry's ROB slot and flags.
REQ-012 SHALL have ports out_set_o  output  1, out_rid_o  output  6: one-cycle pulse setting the ROB "out" flag.
REQ-013 SHALL have ports cmp_valid_i  input  1, cmp_rid_i  input  6: completion return from execute stage.
REQ-014 SHALL have ports inflight_o  output  3, full_o  output  1, ovf_o  output  1, err_o  output  1.

Function
REQ-015 SHALL enqueue {rid, branch, mem} at the clock edge where sel_i[6]=0, queue not full, and rid not already queued.
REQ-016 SHALL assert out_set_o with out_rid_o=sel_i[5:0] in the cycle after each successful enqueue, for exactly one cycle.
REQ-017 SHALL silently drop a selection whose rid matches a queued entry (no enqueue, no out_set_o, no flag).
REQ-018 SHALL drop a valid selection when the queue is full, without out_set_o, and set sticky ovf_o.
REQ-019 SHALL, in the same edge, allow enqueue into the slot freed by a dispatch, so a full queue with a dispatch accepts a new selection.
REQ-020 SHALL drive ex_valid_o = (queue non-empty) AND (inflight < MAX_INFLIGHT), from registered state only.
REQ-021 SHALL hold ex_rid_o, ex_branch_o, ex_mem_o stable while ex_valid_o=1 and ex_ready_i=0.
REQ-022 SHALL dispatch (pop head, inflight+1) on an edge with ex_valid_o=1 and ex_ready_i=1; queue order is FIFO.
REQ-023 SHALL decrement inflight on cmp_valid_i=1; dispatch and completion on the same edge leave inflight unchanged.
REQ-024 SHALL ignore cmp_valid_i when inflight=0 and no dispatch occurs that edge, and set sticky err_o.
REQ-025 SHALL provide first-dispatch latency of 1 cycle: selection at edge N gives ex_valid_o=1 after edge N if inflight < MAX.
REQ-026 SHALL implement states EMPTY (count=0), ISSUE (count>0, inflight<MAX), THROTTLE (count>0, inflight=MAX), with transitions on enqueue/dispatch/completion/flush.
REQ-027 SHALL, on flush_i=1, empty the queue at that edge, ignore that cycle's selection, suppress out_set_o the next cycle, and leave inflight unchanged.
REQ-028 SHALL wrap queue pointers modulo QDEPTH; full_o = (count = QDEPTH).
REQ-029 SHALL expose inflight_o as the current inflight count.

Reset
REQ-030 SHALL, while rst=1, asynchronously force: queue empty, inflight_o=0, ex_valid_o=0, ex_rid_o=0, ex_branch_o=0, ex_mem_o=0, out_set_o=0, out_rid_o=0, full_o=0, ovf_o=0, err_o=0, state EMPTY.
REQ-031 SHALL, on reset mid-operation, discard queued entries and inflight count without emitting out_set_o or ex_valid_o.

Verification
REQ-032 SHALL cover: sel_i=7'h05, ex_ready_i=1 -> out_set_o=1 rid 5 next cycle; ex_valid_o=1, ex_rid_o=5 that cycle; inflight_o=1 after accept.
REQ-033 SHALL cover: ex_ready_i=0, selections 1,2,3,4,6 -> 1..4 queued, full_o=1; 6 dropped, ovf_o=1, no out_set_o for 6; ex_rid_o held at 1.
REQ-034 SHALL cover: four dispatches, no completion -> inflight_o=4, ex_valid_o=0 with queue non-empty; one cmp_valid_i -> ex_valid_o=1 next cycle.
REQ-035 SHALL cover: sel_i=7'h09 twice while 9 queued -> single enqueue, single out_set_o pulse.
REQ-036 SHALL cover: queue holding 3 entries plus flush_i=1 with sel_i=7'h0A -> queue empty, ex_valid_o=0, no out_set_o, inflight_o unchanged.
REQ-037 SHALL cover: cmp_valid_i=1 with inflight_o=0 -> inflight_o stays 0, err_o=1; then rst=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/any1_dispatcher.sv
// any1_dispatcher: FIFO of scheduler selections feeding the execute stage,
// with duplicate filtering, overflow/underflow flags and an in-flight op limit.
module any1_dispatcher #(
    parameter int QDEPTH       = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sel_i,
    input  logic       sel_branch_i,
    input  logic       sel_mem_i,
    input  logic       flush_i,
    output logic       ex_valid_o,
    input  logic       ex_ready_i,
    output logic [5:0] ex_rid_o,
    output logic       ex_branch_o,
    output logic       ex_mem_o,
    output logic       out_set_o,
    output logic [5:0] out_rid_o,
    input  logic       cmp_valid_i,
    input  logic [5:0] cmp_rid_i,
    output logic [2:0] inflight_o,
    output logic       full_o,
    output logic       ovf_o,
    output logic       err_o
);
    localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [2:0] MAXI = 3'(MAX_INFLIGHT);

    typedef enum logic [1:0] {EMPTY, ISSUE, THROTTLE} state_t;

    state_t        state, state_nxt;
    logic [7:0]    q [QDEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    logic [2:0]    inflight, inflight_nxt;
    logic          sel_valid, dup, dispatch, enq, drop_full, cmp_ok, cmp_bad;

    // A selection is a duplicate if its rid matches any live slot between head and tail.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < QDEPTH; i++)
            if (q[i][7:2] == sel_i[5:0] && {1'b0, PW'(i) - head} < count)
                dup = 1'b1;
    end

    assign sel_valid    = !sel_i[6];
    assign dispatch     = ex_valid_o && ex_ready_i;
    assign enq          = sel_valid && !flush_i && !dup && (!full_o || dispatch);
    assign drop_full    = sel_valid && !flush_i && !dup && full_o && !dispatch;
    assign cmp_bad      = cmp_valid_i && inflight == 3'd0 && !dispatch;
    assign cmp_ok       = cmp_valid_i && !cmp_bad;
    assign inflight_nxt = inflight + 3'(dispatch) - 3'(cmp_ok);
    assign count_nxt    = flush_i ? '0 : count + CW'(enq) - CW'(dispatch);

    always_comb begin
        state_nxt = ISSUE;
        if (count_nxt == '0)
            state_nxt = EMPTY;
        else if (inflight_nxt >= MAXI)
            state_nxt = THROTTLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++)
                q[i] <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            inflight  <= '0;
            out_set_o <= 1'b0;
            out_rid_o <= '0;
            ovf_o     <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            if (enq)
                q[tail] <= {sel_i[5:0], sel_branch_i, sel_mem_i};
            tail      <= tail + PW'(enq);
            head      <= flush_i ? tail : head + PW'(dispatch);
            count     <= count_nxt;
            inflight  <= inflight_nxt;
            out_set_o <= enq;
            out_rid_o <= enq ? sel_i[5:0] : '0;
            ovf_o     <= ovf_o || drop_full;
            err_o     <= err_o || cmp_bad;
        end
    end

    assign ex_valid_o  = state == ISSUE;
    assign ex_rid_o    = q[head][7:2];
    assign ex_branch_o = q[head][1];
    assign ex_mem_o    = q[head][0];
    assign full_o      = count == CW'(QDEPTH);
    assign inflight_o  = inflight;

endmodule

// File: tb/tb_any1_dispatcher.sv
// tb_any1_dispatcher: directed vector table plus hand sequences for reset behaviour.
module tb_any1_dispatcher;
    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] sel_i = 7'h7F;
    logic       sel_branch_i = 1'b0, sel_mem_i = 1'b0, flush_i = 1'b0;
    logic       ex_ready_i = 1'b0, cmp_valid_i = 1'b0;
    logic [5:0] cmp_rid_i = '0;
    logic       ex_valid_o, ex_branch_o, ex_mem_o, out_set_o, full_o, ovf_o, err_o;
    logic [5:0] ex_rid_o, out_rid_o;
    logic [2:0] inflight_o;

    any1_dispatcher dut (
        .clk(clk), .rst(rst), .sel_i(sel_i), .sel_branch_i(sel_branch_i),
        .sel_mem_i(sel_mem_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o),
        .ex_ready_i(ex_ready_i), .ex_rid_o(ex_rid_o), .ex_branch_o(ex_branch_o),
        .ex_mem_o(ex_mem_o), .out_set_o(out_set_o), .out_rid_o(out_rid_o),
        .cmp_valid_i(cmp_valid_i), .cmp_rid_i(cmp_rid_i), .inflight_o(inflight_o),
        .full_o(full_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] sel;
        logic [4:0] ctl;   // branch, mem, flush, ready, cmp_valid
        logic [5:0] crid;
        logic [3:0] e;     // ex_valid, ex_branch, ex_mem, out_set
        logic [5:0] erid;
        logic [5:0] eorid;
        logic [2:0] einf;
        logic [2:0] f;     // full, ovf, err
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   misc = 0;

    task automatic add(input logic [6:0] sel, input logic [4:0] ctl, input logic [5:0] crid,
                       input logic [3:0] e, input logic [5:0] erid, input logic [5:0] eorid,
                       input logic [2:0] einf, input logic [2:0] f);
        vec_t v;
        v.sel = sel; v.ctl = ctl; v.crid = crid; v.e = e;
        v.erid = erid; v.eorid = eorid; v.einf = einf; v.f = f;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            misc++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ex_valid"}, -1, {7'd0, ex_valid_o}, 8'd0);
        chk({tag, " ex_rid"}, -1, {2'd0, ex_rid_o}, 8'd0);
        chk({tag, " ex_branch"}, -1, {7'd0, ex_branch_o}, 8'd0);
        chk({tag, " ex_mem"}, -1, {7'd0, ex_mem_o}, 8'd0);
        chk({tag, " out_set"}, -1, {7'd0, out_set_o}, 8'd0);
        chk({tag, " out_rid"}, -1, {2'd0, out_rid_o}, 8'd0);
        chk({tag, " inflight"}, -1, {5'd0, inflight_o}, 8'd0);
        chk({tag, " flags"}, -1, {5'd0, full_o, ovf_o, err_o}, 8'd0);
    endtask

    initial begin
        // single op: enqueue, dispatch, complete
        add(7'h05, 5'b00010, 6'd0, 4'b1001, 6'h05, 6'h05, 3'd0, 3'b000);
        add(7'h7F, 5'b00010, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd1, 3'b000);
        add(7'h7F, 5'b00001, 6'd5, 4'b0000, 6'h00, 6'h00, 3'd0, 3'b000);
        // fill with ready low, overflow on 6
        add(7'h01, 5'b10000, 6'd0, 4'b1101, 6'h01, 6'h01, 3'd0, 3'b000);
        add(7'h02, 5'b01000, 6'd0, 4'b1101, 6'h01, 6'h02, 3'd0, 3'b000);
        add(7'h03, 5'b00000, 6'd0, 4'b1101, 6'h01, 6'h03, 3'd0, 3'b000);
        add(7'h04, 5'b00000, 6'd0, 4'b1101, 6'h01, 6'h04, 3'd0, 3'b100);
        add(7'h06, 5'b00000, 6'd0, 4'b1100, 6'h01, 6'h00, 3'd0, 3'b110);
        // full queue with dispatch accepts a selection
        add(7'h07, 5'b00010, 6'd0, 4'b1011, 6'h02, 6'h07, 3'd1, 3'b110);
        // throttle at MAX_INFLIGHT
        add(7'h7F, 5'b00010, 6'd0, 4'b1000, 6'h03, 6'h00, 3'd2, 3'b010);
        add(7'h7F, 5'b00010, 6'd0, 4'b1000, 6'h04, 6'h00, 3'd3, 3'b010);
        add(7'h7F, 5'b00010, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd4, 3'b010);
        add(7'h7F, 5'b00010, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd4, 3'b010);
        add(7'h7F, 5'b00001, 6'd1, 4'b1000, 6'h07, 6'h00, 3'd3, 3'b010);
        add(7'h7F, 5'b00011, 6'd2, 4'b0000, 6'h00, 6'h00, 3'd3, 3'b010);
        // duplicate selection
        add(7'h09, 5'b00000, 6'd0, 4'b1001, 6'h09, 6'h09, 3'd3, 3'b010);
        add(7'h09, 5'b00000, 6'd0, 4'b1000, 6'h09, 6'h00, 3'd3, 3'b010);
        add(7'h7F, 5'b00000, 6'd0, 4'b1000, 6'h09, 6'h00, 3'd3, 3'b010);
        add(7'h7F, 5'b00011, 6'd3, 4'b0000, 6'h00, 6'h00, 3'd3, 3'b010);
        // flush with three queued
        add(7'h0B, 5'b00000, 6'd0, 4'b1001, 6'h0B, 6'h0B, 3'd3, 3'b010);
        add(7'h0C, 5'b00000, 6'd0, 4'b1001, 6'h0B, 6'h0C, 3'd3, 3'b010);
        add(7'h0E, 5'b00000, 6'd0, 4'b1001, 6'h0B, 6'h0E, 3'd3, 3'b010);
        add(7'h0A, 5'b00100, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd3, 3'b010);
        add(7'h7F, 5'b00000, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd3, 3'b010);
        add(7'h0B, 5'b00000, 6'd0, 4'b1001, 6'h0B, 6'h0B, 3'd3, 3'b010);
        // drain, then a spurious completion
        add(7'h7F, 5'b00010, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd4, 3'b010);
        add(7'h7F, 5'b00001, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd3, 3'b010);
        add(7'h7F, 5'b00001, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd2, 3'b010);
        add(7'h7F, 5'b00001, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd1, 3'b010);
        add(7'h7F, 5'b00001, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd0, 3'b010);
        add(7'h7F, 5'b00001, 6'd0, 4'b0000, 6'h00, 6'h00, 3'd0, 3'b011);

        #12;
        nvec++;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[k]) begin
            sel_i = vq[k].sel;
            {sel_branch_i, sel_mem_i, flush_i, ex_ready_i, cmp_valid_i} = vq[k].ctl;
            cmp_rid_i = vq[k].crid;
            @(posedge clk);
            #1;
            nvec++;
            chk("ex_valid", k, {7'd0, ex_valid_o}, {7'd0, vq[k].e[3]});
            if (vq[k].e[3]) begin
                chk("ex_rid", k, {2'd0, ex_rid_o}, {2'd0, vq[k].erid});
                chk("ex_flags", k, {6'd0, ex_branch_o, ex_mem_o}, {6'd0, vq[k].e[2:1]});
            end
            chk("out_set", k, {7'd0, out_set_o}, {7'd0, vq[k].e[0]});
            if (vq[k].e[0])
                chk("out_rid", k, {2'd0, out_rid_o}, {2'd0, vq[k].eorid});
            chk("inflight", k, {5'd0, inflight_o}, {5'd0, vq[k].einf});
            chk("full/ovf/err", k, {5'd0, full_o, ovf_o, err_o}, {5'd0, vq[k].f});
        end

        // asynchronous reset mid-operation clears everything without a clock edge
        sel_i = 7'h01;
        {sel_branch_i, sel_mem_i, flush_i, ex_ready_i, cmp_valid_i} = 5'b0;
        @(posedge clk);
        #1;
        nvec++;
        chk("pre-reset valid/out_set", -1, {6'd0, ex_valid_o, out_set_o}, 8'b11);
        sel_i = 7'h7F;
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        chk_zero("async reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        chk_zero("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, misc);
        $finish;
    end
endmodule
